// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div/accumulate ops
// and single-cycle mthi/mtlo, and exposes HI/LO to the E/M result mux.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDU_op,
  input  logic        start,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [3:0] {
    OpNone, OpMult, OpMultu, OpDiv, OpDivu, OpMadd, OpMaddu, OpMsub, OpMsubu,
    OpMthi, OpMtlo, OpMfhi, OpMflo
  } md_op_e;

  md_op_e            op;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d, ph_q, ph_d, pl_q, pl_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d, dz_q, dz_d;
  logic              is_long, is_div, is_signed;
  logic [63:0]       ext_a, ext_b, prod, acc, result;
  logic [31:0]       abs_a, abs_b, div_b, q_mag, r_mag, quo, rem;

  assign op        = md_op_e'(MDU_op);
  assign is_long   = (MDU_op >= 4'd1) && (MDU_op <= 4'd8);
  assign is_div    = (op == OpDiv) || (op == OpDivu);
  assign is_signed = (op == OpMult) || (op == OpDiv) || (op == OpMadd) || (op == OpMsub);

  // Low 64 bits of a product of extended operands are exact for both signednesses.
  assign ext_a = {{32{is_signed & A[31]}}, A};
  assign ext_b = {{32{is_signed & B[31]}}, B};
  assign prod  = ext_a * ext_b;
  assign acc   = {hi_q, lo_q};

  // Divide on magnitudes so 0x80000000 / -1 needs no special case.
  assign abs_a = (is_signed && A[31]) ? (32'd0 - A) : A;
  assign abs_b = (is_signed && B[31]) ? (32'd0 - B) : B;
  assign div_b = (B == 32'd0) ? 32'd1 : abs_b;
  assign q_mag = abs_a / div_b;
  assign r_mag = abs_a % div_b;
  assign quo   = (is_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem   = (is_signed && A[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    result = prod;
    case (op)
      OpDiv, OpDivu:   result = {rem, quo};
      OpMadd, OpMaddu: result = acc + prod;
      OpMsub, OpMsubu: result = acc - prod;
      default:         result = prod;
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    ph_d   = ph_q;
    pl_d   = pl_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    dz_d   = dz_q;
    if (busy_q) begin
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (!dz_q) begin
          hi_d = ph_q;
          lo_d = pl_q;
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else if (start && !flush) begin
      if (op == OpMthi) begin
        hi_d = A;
      end else if (op == OpMtlo) begin
        lo_d = A;
      end else if (is_long) begin
        {ph_d, pl_d} = result;
        cnt_d        = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        busy_d       = 1'b1;
        dz_d         = is_div && (B == 32'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      ph_q   <= '0;
      pl_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      ph_q   <= ph_d;
      pl_q   <= pl_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      dz_q   <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign stall_req = busy_q | (start & is_long & ~flush);
  assign HI        = hi_q;
  assign LO        = lo_q;

  always_comb begin
    mdu_out = 32'd0;
    if (op == OpMfhi) mdu_out = hi_q;
    else if (op == OpMflo) mdu_out = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed-vector bench for e_mdu: hand-computed HI/LO results, busy length,
// stall_req, flush/busy drop, divide by zero and mid-operation reset.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [3:0]  MDU_op;
  logic        start, flush;
  logic        busy, stall_req;
  logic [31:0] HI, LO, mdu_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .MDU_op    (MDU_op),
    .start     (start),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .HI        (HI),
    .LO        (LO),
    .mdu_out   (mdu_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one edge; stall_req is checked combinationally before the edge.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic exp_stall);
    A = a; B = b; MDU_op = op; start = 1'b1;
    #1;
    check({tag, ".stall"}, {31'd0, stall_req}, {31'd0, exp_stall});
    step();
    start = 1'b0; MDU_op = 4'd0;
  endtask

  // Count remaining edges until busy drops; bounded so a stuck busy is reported.
  task automatic wait_idle(input string tag, input int exp_edges);
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    check({tag, ".busy_len"}, 32'(n), 32'(exp_edges));
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
    check({tag, ".hi"}, HI, exp_hi);
    check({tag, ".lo"}, LO, exp_lo);
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; MDU_op = '0; start = 1'b0; flush = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.stall", {31'd0, stall_req}, 32'd0);
    check_hilo("rst", 32'd0, 32'd0);

    issue("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("mult.busy", {31'd0, busy}, 32'd1);
    check("mult.hold_lo", LO, 32'd0);
    wait_idle("mult", 5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    issue("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle("multu", 5);
    check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    issue("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div", 10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue("divu", 4'd4, 32'd7, 32'd2, 1'b1);
    wait_idle("divu", 10);
    check_hilo("divu", 32'd1, 32'd3);

    issue("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle("divovf", 10);
    check_hilo("divovf", 32'd0, 32'h8000_0000);

    issue("mtlo", 4'd10, 32'd5, 32'd0, 1'b0);
    check("mtlo.busy", {31'd0, busy}, 32'd0);
    check("mtlo.lo", LO, 32'd5);
    issue("mthi", 4'd9, 32'd0, 32'd0, 1'b0);
    check("mthi.hi", HI, 32'd0);
    issue("madd", 4'd5, 32'd3, 32'd4, 1'b1);
    wait_idle("madd", 5);
    check_hilo("madd", 32'd0, 32'h11);
    issue("msub", 4'd7, 32'd3, 32'd6, 1'b1);
    wait_idle("msub", 5);
    check_hilo("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    MDU_op = 4'd11; #1;
    check("mfhi", mdu_out, 32'hFFFF_FFFF);
    MDU_op = 4'd12; #1;
    check("mflo", mdu_out, 32'hFFFF_FFFF);
    MDU_op = 4'd0; #1;
    check("mfnone", mdu_out, 32'd0);

    issue("mthi2", 4'd9, 32'h0000_AAAA, 32'd0, 1'b0);
    issue("mtlo2", 4'd10, 32'h0000_5555, 32'd0, 1'b0);
    issue("divz", 4'd4, 32'd9, 32'd0, 1'b1);
    wait_idle("divz", 10);
    check_hilo("divz", 32'h0000_AAAA, 32'h0000_5555);

    flush = 1'b1;
    issue("flush", 4'd1, 32'd3, 32'd3, 1'b0);
    flush = 1'b0;
    check("flush.busy", {31'd0, busy}, 32'd0);
    check_hilo("flush", 32'h0000_AAAA, 32'h0000_5555);

    issue("inbusy", 4'd2, 32'd3, 32'd5, 1'b1);
    A = 32'h0000_DEAD; MDU_op = 4'd9; start = 1'b1;
    #1;
    check("inbusy.stall", {31'd0, stall_req}, 32'd1);
    step();
    start = 1'b0; MDU_op = 4'd0;
    check("inbusy.hi_hold", HI, 32'h0000_AAAA);
    wait_idle("inbusy", 4);
    check_hilo("inbusy", 32'd0, 32'd15);

    issue("rstmid", 4'd3, 32'd100, 32'd7, 1'b1);
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstmid.busy", {31'd0, busy}, 32'd0);
    check_hilo("rstmid", 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) step();
    check("rstmid.busy_late", {31'd0, busy}, 32'd0);
    check_hilo("rstmid_late", 32'd0, 32'd0);
    MDU_op = 4'd12; #1;
    check("rstmid.mflo", mdu_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
